// File: rtl/line_mem_pkg.sv
// Shared types and constants for the line_mem main-memory responder.
// Used by line_mem and lfsr16.
package line_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GNT
  } state_e;

  localparam int unsigned CNT_W     = 9;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16/14/13/11, expressed as bit positions 15/13/12/10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that steps only when adv is high.
// Present only in builds with LINE_MEM_RAND_LAT_EN defined.
`ifdef LINE_MEM_RAND_LAT_EN
module lfsr16
  import line_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] q
);

  logic [15:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= LFSR_SEED;
    end else if (adv) begin
      q_q <= lfsr_next(q_q);
    end
  end

  assign q = q_q;

endmodule
`endif

// File: rtl/line_mem.sv
// Line-granular main memory with programmable latency and a one-cycle gnt pulse.
// Define LINE_MEM_RAND_LAT_EN for LFSR-driven random latency in 1..2*LATENCY.
module line_mem
  import line_mem_pkg::*;
#(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned ADDR_LEN      = 9,
  parameter int unsigned LATENCY       = 50
) (
  input  logic                clk,
  input  logic                rst,
  output logic                gnt,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic                rd_req,
  output logic [31:0]         rd_line [2**LINE_ADDR_LEN],
  input  logic                wr_req,
  input  logic [31:0]         wr_line [2**LINE_ADDR_LEN]
);

  localparam int unsigned LINE_SIZE = 2 ** LINE_ADDR_LEN;
  localparam int unsigned NUM_LINES = 2 ** ADDR_LEN;

  // Storage powers up zeroed and is kept XOR-scrambled with the initial pattern,
  // so an untouched word reads back as (line << LINE_ADDR_LEN) | word.
  function automatic logic [31:0] init_word(input logic [ADDR_LEN-1:0] a,
                                            input int unsigned k);
    return 32'({a, LINE_ADDR_LEN'(k)});
  endfunction

  state_e              state_q;
  logic                gnt_q;
  logic                op_wr_q;
  logic [ADDR_LEN-1:0] addr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [31:0]         wr_line_q [LINE_SIZE];
  logic [31:0]         rd_line_q [LINE_SIZE];
  logic [31:0]         mem_q [NUM_LINES][LINE_SIZE];

  logic             accept;
  logic             req_held;
  logic             mem_we;
  logic [CNT_W-1:0] cnt_load;

  assign accept   = (state_q == IDLE) && (wr_req || rd_req);
  assign req_held = op_wr_q ? wr_req : rd_req;
  assign mem_we   = !rst && (state_q == BUSY) && op_wr_q && wr_req && (cnt_q == '0);

`ifdef LINE_MEM_RAND_LAT_EN
  logic [15:0] lfsr_q;

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .adv (accept),
    .q   (lfsr_q)
  );

  assign cnt_load = CNT_W'(lfsr_q % 16'(2 * LATENCY));
`else
  assign cnt_load = CNT_W'(LATENCY - 1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < LINE_SIZE; k++) begin
        rd_line_q[k] <= '0;
      end
    end else begin
      gnt_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            // Write wins when both are requested; the read stays pending.
            op_wr_q <= wr_req;
            addr_q  <= addr;
            cnt_q   <= cnt_load;
            state_q <= BUSY;
            if (wr_req) begin
              for (int k = 0; k < LINE_SIZE; k++) begin
                wr_line_q[k] <= wr_line[k];
              end
            end
          end
        end
        BUSY: begin
          if (!req_held) begin
            state_q <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (!op_wr_q) begin
              for (int k = 0; k < LINE_SIZE; k++) begin
                rd_line_q[k] <= mem_q[addr_q][k] ^ init_word(addr_q, k);
              end
            end
            gnt_q   <= 1'b1;
            state_q <= GNT;
          end
        end
        GNT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < LINE_SIZE; k++) begin
        mem_q[addr_q][k] <= wr_line_q[k] ^ init_word(addr_q, k);
      end
    end
  end

  assign gnt     = gnt_q;
  assign rd_line = rd_line_q;

endmodule

// File: tb/tb_line_mem.sv
// Scoreboard bench for line_mem at LATENCY=4: stimulus queues expectations,
// a negedge monitor checks every gnt pulse for latency and read data.
module tb_line_mem;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        gnt;
  logic [8:0]  addr;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] rd_line [8];
  logic [31:0] wr_line [8];

  line_mem #(
    .LINE_ADDR_LEN (3),
    .ADDR_LEN      (9),
    .LATENCY       (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .gnt     (gnt),
    .addr    (addr),
    .rd_req  (rd_req),
    .rd_line (rd_line),
    .wr_req  (wr_req),
    .wr_line (wr_line)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic         is_rd;
    logic [31:0]  req_cyc;
    logic [255:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests   = 0;
  int   fails   = 0;
  int   gnt_cnt = 0;

  function automatic logic [255:0] seq(input logic [31:0] base);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = base + 32'(k);
    return v;
  endfunction

  function automatic logic [255:0] cur_rd();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = rd_line[k];
    return v;
  endfunction

  task automatic check_line(input string name, input logic [255:0] act,
                            input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: every gnt pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (gnt === 1'b1) begin
      gnt_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected gnt: got gnt in cycle %0d required none", cyc);
      end else begin
        mon_e = sb.pop_front();
`ifdef LINE_MEM_RAND_LAT_EN
        tests++;
        if ((cyc - int'(mon_e.req_cyc)) < 2 || (cyc - int'(mon_e.req_cyc)) > 2 * LAT + 1) begin
          fails++;
          $display("FAIL gnt latency: got %0d required 2..%0d",
                   cyc - int'(mon_e.req_cyc), 2 * LAT + 1);
        end
`else
        check_int("gnt latency", cyc - int'(mon_e.req_cyc), LAT + 1);
`endif
        if (mon_e.is_rd) check_line("rd_line at gnt", cur_rd(), mon_e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 into the cycle after gnt.
  task automatic wait_gnt(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (gnt === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: got no gnt required gnt", name);
    end
    step();
  endtask

  task automatic set_wr(input logic [31:0] base);
    for (int k = 0; k < 8; k++) wr_line[k] = base + 32'(k);
  endtask

  task automatic do_read(input logic [8:0] a, input logic [255:0] exp);
    addr   = a;
    rd_req = 1'b1;
    sb.push_back({1'b1, 32'(cyc), exp});
    wait_gnt("read");
    rd_req = 1'b0;
  endtask

  task automatic do_write(input logic [8:0] a, input logic [31:0] base);
    addr = a;
    set_wr(base);
    wr_req = 1'b1;
    sb.push_back({1'b0, 32'(cyc), 256'(0)});
    wait_gnt("write");
    wr_req = 1'b0;
  endtask

  initial begin
    int base;
    rst    = 1'b1;
    addr   = '0;
    rd_req = 1'b0;
    wr_req = 1'b0;
    set_wr(32'h0);
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check_int("reset gnt", int'(gnt), 0);
    check_line("reset rd_line", cur_rd(), '0);
    step();

    // Initial contents and write/read-back.
    do_read(9'd5, seq(32'd40));
    do_write(9'd3, 32'hA5A5_0000);
    do_read(9'd3, seq(32'hA5A5_0000));
    do_read(9'd2, seq(32'd16));

    // Aborted read: no gnt, rd_line keeps line 2.
    base   = gnt_cnt;
    addr   = 9'd7;
    rd_req = 1'b1;
    step();
    step();
    rd_req = 1'b0;
    repeat (10) step();
    check_int("abort read gnt count", gnt_cnt - base, 0);
    check_line("abort read rd_line", cur_rd(), seq(32'd16));

    // Aborted write: line 6 untouched.
    base   = gnt_cnt;
    addr   = 9'd6;
    set_wr(32'hDEAD_0000);
    wr_req = 1'b1;
    step();
    step();
    wr_req = 1'b0;
    repeat (10) step();
    check_int("abort write gnt count", gnt_cnt - base, 0);
    do_read(9'd6, seq(32'd48));

    // Write-back then refill, back to back.
    do_write(9'd1, 32'h1111_0000);
    do_read(9'd9, seq(32'd72));
    check_line("swap rd_line hold", cur_rd(), seq(32'd72));
    do_read(9'd1, seq(32'h1111_0000));

    // Both requests high: write first, addr/wr_line changes after accept ignored.
    addr = 9'd4;
    set_wr(32'hC0DE_0000);
    wr_req = 1'b1;
    rd_req = 1'b1;
    sb.push_back({1'b0, 32'(cyc), 256'(0)});
    step();
    addr = 9'd10;
    set_wr(32'hFFFF_FFFF);
    wait_gnt("simul write");
    wr_req = 1'b0;
    sb.push_back({1'b1, 32'(cyc), seq(32'd80)});
    wait_gnt("simul read");
    rd_req = 1'b0;
    do_read(9'd4, seq(32'hC0DE_0000));

    // Reset in the middle of a write.
    base   = gnt_cnt;
    addr   = 9'd12;
    set_wr(32'hBAD0_0000);
    wr_req = 1'b1;
    step();
    step();
    rst    = 1'b1;
    wr_req = 1'b0;
    step();
    rst = 1'b0;
    repeat (8) step();
    check_int("reset mid-busy gnt count", gnt_cnt - base, 0);
    check_line("reset mid-busy rd_line", cur_rd(), '0);
    do_read(9'd12, seq(32'd96));

    repeat (5) step();
    check_int("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required completion");
    $fatal(1, "watchdog");
  end

endmodule
